mem_port_arbiter: RTL and testbench

//  Shares one unified memory port between instruction fetch and the load/store path of core_datapath.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one access in flight.
// Data wins ties; an optional watchdog aborts an access that never completes.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                bus_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, M_REQ, M_WAIT, RESP} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;
  logic              done_ok;
  logic              done_abort;

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = bus_err_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 1'b1;
    timeout_hit = (TIMEOUT > 0) && (cnt_inc == TIMEOUT_CNT);
    done_ok     = 1'b0;
    done_abort  = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req) begin
          owner_d     = OWN_D;
          mem_we_d    = d_we;
          mem_be_d    = d_be;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          cnt_d       = '0;
          state_d     = M_REQ;
        end else if (if_req) begin
          owner_d     = OWN_IF;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          cnt_d       = '0;
          state_d     = M_REQ;
        end
      end
      M_REQ: begin
        cnt_d = cnt_inc;
        if (timeout_hit) done_abort = 1'b1;
        else if (mem_gnt) state_d = M_WAIT;
      end
      M_WAIT: begin
        cnt_d = cnt_inc;
        // A real completion on the last counted cycle beats the watchdog.
        if (mem_rvalid) done_ok = 1'b1;
        else if (timeout_hit) done_abort = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (done_ok || done_abort) state_d = RESP;

    if (done_abort) begin
      bus_err_d = 1'b1;
      if (owner_q == OWN_D) d_rdata_d = '0;
      else                  if_rdata_d = '0;
    end

    if (done_ok && !mem_we_q) begin
      if (owner_q == OWN_D) d_rdata_d = mem_rdata;
      else                  if_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the data registers are reset too, since every output must read 0 out of reset.
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values regardless of order.
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_req   = (state_q == M_REQ);
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = (state_q == RESP) && (owner_q == OWN_IF);
  assign d_valid   = (state_q == RESP) && (owner_q == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_err   = bus_err_q;
  assign stall     = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model checked every cycle, a
// behavioural memory with programmable grant/response delays, and directed scenarios.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_valid, d_req, d_we, d_valid;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, stall, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory subsystem model and its knobs.
  logic [31:0] mem_arr [0:255];
  int  gnt_delay    = 0;
  int  rv_delay     = 0;
  bit  rv_never     = 1'b0;
  bit  force_gnt    = 1'b0;
  bit  force_rvalid = 1'b0;

  initial begin
    bit          accepted, fired, rv_real, rsp_pending, rsp_we;
    int          rsp_wait, req_age;
    logic [31:0] a_addr, a_wdata, rsp_addr, rsp_wdata;
    logic [3:0]  a_be, rsp_be;
    bit          a_we;
    rv_real = 1'b0; rsp_pending = 1'b0; rsp_wait = 0; req_age = 0;
    rsp_we = 1'b0; rsp_addr = '0; rsp_wdata = '0; rsp_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      accepted = (mem_req === 1'b1) && mem_gnt;
      fired    = rv_real;
      a_addr = mem_addr; a_wdata = mem_wdata; a_be = mem_be; a_we = mem_we;
      #1;
      if (fired) rsp_pending = 1'b0;
      if (accepted) begin
        rsp_pending = 1'b1; rsp_wait = rv_delay;
        rsp_addr = a_addr; rsp_wdata = a_wdata; rsp_be = a_be; rsp_we = a_we;
      end
      if (rv_never) rsp_pending = 1'b0;
      rv_real   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      if (rsp_pending) begin
        if (rsp_wait == 0) begin
          rv_real = 1'b1;
          if (rsp_we) begin
            for (int b = 0; b < 4; b++)
              if (rsp_be[b]) mem_arr[rsp_addr[9:2]][8*b +: 8] = rsp_wdata[8*b +: 8];
          end else begin
            mem_rdata = mem_arr[rsp_addr[9:2]];
          end
        end else begin
          rsp_wait--;
        end
      end
      mem_rvalid = rv_real | force_rvalid;
      if (mem_req === 1'b1) begin
        mem_gnt = (req_age >= gnt_delay);
        req_age++;
      end else begin
        req_age = 0;
        mem_gnt = 1'b0;
      end
      mem_gnt = mem_gnt | force_gnt;
    end
  end

  // Transaction-level reference: one access at a time, data first, age-limited.
  bit          m_busy = 0, m_granted = 0, m_resp = 0, m_owner_d = 0, m_we = 0, m_bus_err = 0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_d_rdata = '0;
  int          m_age = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0; m_granted <= 0; m_resp <= 0; m_owner_d <= 0; m_we <= 0; m_be <= '0;
      m_addr <= '0; m_wdata <= '0; m_if_rdata <= '0; m_d_rdata <= '0; m_bus_err <= 0; m_age <= 0;
    end else if (m_resp) begin
      m_resp <= 0;
    end else if (!m_busy) begin
      if (d_req || if_req) begin
        m_busy <= 1; m_granted <= 0; m_age <= 0; m_owner_d <= d_req;
        m_addr  <= d_req ? d_addr : if_addr;
        m_we    <= d_req && d_we;
        m_be    <= d_req ? d_be : 4'hF;
        m_wdata <= d_req ? d_wdata : 32'h0;
      end
    end else begin
      m_age <= m_age + 1;
      if (m_granted && mem_rvalid) begin
        m_busy <= 0; m_resp <= 1;
        if (!m_we) begin
          if (m_owner_d) m_d_rdata <= mem_rdata;
          else           m_if_rdata <= mem_rdata;
        end
      end else if (m_age + 1 == TIMEOUT) begin
        m_busy <= 0; m_resp <= 1; m_bus_err <= 1;
        if (m_owner_d) m_d_rdata <= '0;
        else           m_if_rdata <= '0;
      end else if (!m_granted && mem_gnt) begin
        m_granted <= 1;
      end
    end
  end

  bit cmp_en    = 1'b0;
  int if_pulses = 0;
  int d_pulses  = 0;

  initial begin
    bit e_req, e_ifv, e_dv;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e_req = m_busy && !m_granted;
        e_ifv = m_resp && !m_owner_d;
        e_dv  = m_resp && m_owner_d;
        check("mem_req", mem_req, e_req);
        check("if_valid", if_valid, e_ifv);
        check("d_valid", d_valid, e_dv);
        check("if_rdata", if_rdata, m_if_rdata);
        check("d_rdata", d_rdata, m_d_rdata);
        check("bus_err", bus_err, m_bus_err);
        check("stall", stall, (if_req && !e_ifv) || (d_req && !e_dv));
        if (e_req) begin
          check("mem_addr", mem_addr, m_addr);
          check("mem_we", mem_we, m_we);
          check("mem_be", mem_be, m_be);
          if (m_owner_d) check("mem_wdata", mem_wdata, m_wdata);
        end
        if (if_valid) if_pulses++;
        if (d_valid) d_pulses++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles from the current cycle to the valid pulse, leaving time at the start of the next cycle.
  task automatic wait_valid(input string name, input bit is_d, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (is_d ? d_valid : if_valid) begin
        lat = i;
        break;
      end
      tick();
    end
    check({name, "_seen"}, (lat >= 0), 1'b1);
    tick();
  endtask

  initial begin
    int lat, ifp0, dp0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA000_0000 + i;
    mem_arr[4]  = 32'h0050_0093;
    mem_arr[64] = 32'h1234_5678;
    reset = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;

    tick(); tick();
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_bus_err", bus_err, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // Zero-wait fetch with exact cycle timing.
    gnt_delay = 0; rv_delay = 0;
    if_req = 1; if_addr = 32'h10;
    @(negedge clk); check("f_c0_stall", stall, 1'b1); check("f_c0_req", mem_req, 1'b0); tick();
    @(negedge clk); check("f_c1_req", mem_req, 1'b1); check("f_c1_addr", mem_addr, 32'h10); tick();
    @(negedge clk); check("f_c2_req", mem_req, 1'b0); check("f_c2_stall", stall, 1'b1); tick();
    @(negedge clk); check("f_c3_valid", if_valid, 1'b1); check("f_c3_rdata", if_rdata, 32'h0050_0093);
    check("f_c3_stall", stall, 1'b0);
    tick();
    if_req = 0;
    tick();

    // Reset while waiting for rvalid; the late rvalid must be ignored.
    ifp0 = if_pulses;
    rv_delay = 1;
    if_req = 1; if_addr = 32'h14;
    tick(); tick();
    reset = 1; if_req = 0;
    tick();
    reset = 0;
    @(negedge clk);
    check("r_mem_req", mem_req, 1'b0);
    check("r_mem_addr", mem_addr, 32'h0);
    check("r_mem_be", mem_be, 4'h0);
    check("r_if_rdata", if_rdata, 32'h0);
    check("r_if_valid", if_valid, 1'b0);
    check("r_late_rvalid", mem_rvalid, 1'b1);
    tick(); tick(); tick();
    check("r_no_pulse", if_pulses - ifp0, 0);

    // Both requesters at once: data first.
    ifp0 = if_pulses; dp0 = d_pulses;
    gnt_delay = 1; rv_delay = 0;
    if_req = 1; if_addr = 32'h18; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h100;
    tick();
    @(negedge clk); check("s_first_addr", mem_addr, 32'h100); check("s_first_we", mem_we, 1'b0);
    tick();
    wait_valid("s_d", 1'b1, 12, lat);
    check("s_d_rdata", d_rdata, 32'h1234_5678);
    d_req = 0;
    wait_valid("s_if", 1'b0, 12, lat);
    check("s_if_rdata", if_rdata, 32'hA000_0006);
    if_req = 0;
    tick(); tick();
    check("s_if_pulses", if_pulses - ifp0, 1);
    check("s_d_pulses", d_pulses - dp0, 1);

    // Store with a three-cycle grant delay; requester inputs wander mid-access.
    gnt_delay = 3; rv_delay = 1;
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'hCAFE_1234;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin d_wdata = 32'hFFFF_FFFF; d_addr = 32'h24; d_be = 4'hF; force_rvalid = 1; end
      if (c == 4) force_rvalid = 0;
      @(negedge clk);
      check("st_req", mem_req, 1'b1);
      check("st_we", mem_we, 1'b1);
      check("st_be", mem_be, 4'b0011);
      check("st_addr", mem_addr, 32'h20);
      check("st_wdata", mem_wdata, 32'hCAFE_1234);
      tick();
    end
    force_rvalid = 0;
    wait_valid("st", 1'b1, 12, lat);
    check("st_lat", lat, 2);
    check("st_d_rdata", d_rdata, 32'h1234_5678);
    d_req = 0; d_we = 0;
    tick();
    check("st_mem_word", mem_arr[8], 32'hA000_1234);

    // Stray grant/rvalid while idle.
    ifp0 = if_pulses; dp0 = d_pulses;
    force_gnt = 1; force_rvalid = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); check("stray_req", mem_req, 1'b0); tick();
    end
    force_gnt = 0; force_rvalid = 0;
    check("stray_pulses", (if_pulses - ifp0) + (d_pulses - dp0), 0);

    // Watchdog: granted load that never completes.
    gnt_delay = 0; rv_never = 1;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h40;
    wait_valid("to", 1'b1, 20, lat);
    check("to_lat", lat, 9);
    check("to_d_rdata", d_rdata, 32'h0);
    check("to_bus_err", bus_err, 1'b1);
    d_req = 0; rv_never = 0;
    tick(); tick();
    check("to_sticky", bus_err, 1'b1);

    // Back-to-back fetches with random memory latency.
    for (int k = 0; k < 4; k++) begin
      gnt_delay = $urandom_range(0, 2);
      rv_delay  = $urandom_range(0, 2);
      if_req = 1; if_addr = 32'(k * 4);
      wait_valid("b2b", 1'b0, 20, lat);
      check("b2b_rdata", if_rdata, mem_arr[k]);
      check("b2b_model", if_rdata, 32'hA000_0000 + 32'(k));
    end
    if_req = 0;
    tick(); tick();
    check("b2b_bus_err", bus_err, 1'b1);

    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    check("fin_bus_err", bus_err, 1'b0);
    check("fin_if_rdata", if_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
